alu_core_param: RTL
===================

# alu_core_param

Parametrised successor to the team's 4-bit two-register ALU datapath. It holds a WIDTH-bit register file of NREGS entries and executes one operation at a time under a valid/ready handshake. Single-cycle ops complete in one cycle; a multi-cycle shift-add multiplier handles MUL. Results are held under a valid/ready output handshake with optional register writeback. It sits between the controller FSM and the register-file loaders, replacing the fixed 4-bit datapath.

## Interface
- WIDTH, 8, operand/register width (≥4, power of 2)
- NREGS, 4, register-file depth (≥2, power of 2); AW = $clog2(NREGS), SW = $clog2(WIDTH)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  external register write strobe
- wr_addr  in  AW  external write address
- wr_data  in  WIDTH  external write data
- op_valid  in  1  operation request
- op_ready  out  1  core can accept (state IDLE)
- op_code  in  4  operation select
- src_a, src_b  in  AW each  operand register addresses
- dst  in  AW  writeback address
- wb_en  in  1  write result low half to dst
- res_valid  out  1  result held
- res_ready  in  1  result consumed
- res_data  out  2*WIDTH  result (upper WIDTH zero except MUL)
- flag_z, flag_c, flag_v, flag_n  out  1 each  zero, carry, signed overflow, negative
- err  out  1  illegal op_code for the held result

## Operation
- Reset (rst=1 at edge): all registers 0, state IDLE, res_valid=0, res_data=0, all flags 0, err=0. A reset during EXEC aborts the MUL with no writeback.
- States: IDLE → EXEC (MUL only) → DONE → IDLE. op_ready = (state==IDLE). Accept = op_valid & op_ready. Op fields and operand values a=R[src_a], b=R[src_b] are latched on the accept edge, using the pre-edge register contents.
- op_code: 0 ADD; 1 SUB (a+~b+1); 2 AND; 3 OR; 4 XOR; 5 SHL by b[SW-1:0]; 6 SHR logical; 7 ASR; 8 CMP (SUB flags, res_data = difference, writeback suppressed); 9 MUL unsigned, 2*WIDTH product; 10–15 illegal (res_data=0, flags 0, err=1, no writeback).
- Flags are computed on the final result and are stable while res_valid=1.
  - Z: res_data==0.
  - N: bit WIDTH-1 (MUL: bit 2*WIDTH-1).
  - C: ADD = carry out. SUB/CMP = no-borrow (a ≥ b unsigned). Shifts = last bit shifted out (0 if amount 0). MUL = upper half ≠ 0. Logic ops = 0.
  - V: signed overflow for ADD/SUB/CMP, else 0.
- MUL: shift-add, one multiplier bit per cycle LSB-first, WIDTH iterations in EXEC.
- Writeback: if wb_en and the op is legal and not CMP, R[dst] ← res_data[WIDTH-1:0] on the edge entering DONE.
- Write port: wr_en writes any time, including in DONE and EXEC. If wr_en and a writeback hit the same address on the same edge, the writeback wins. Different addresses: both are written.
- The MUL source registers may be overwritten during EXEC; the operands were latched at accept, so this has no effect on the result.
- DONE: res_valid=1; res_data, flags and err are held until res_valid & res_ready, then IDLE. No new op is accepted before the cycle after the handshake.

## Timing
- Single-cycle op accepted at edge N: res_valid=1 from N+1. Earliest next accept is edge N+2 if res_ready=1 during cycle N+1.
- MUL accepted at edge N: EXEC for edges N+1..N+WIDTH; res_valid=1 from N+WIDTH+1. With WIDTH=8 that is 9 cycles accept-to-valid.
- op_ready, res_valid and err are registered-state functions. There is no combinational path from op_valid or res_ready to any output.
- res_ready held low: the result is held indefinitely, and op_ready stays 0.

## Test plan
- Reset and hold: rst=1 for 2 cycles mid-MUL → res_valid=0, op_ready=1, R0..R3=0, no writeback to dst.
- ADD overflow (WIDTH=8): R0=0x7F, R1=0x01, ADD wb_en dst=2 → res_data=0x0080, V=1, N=1, C=0, Z=0, R2=0x80 one cycle after accept.
- SUB/CMP borrow: R0=0x05, R1=0x07 → SUB gives 0xFE, C=0, N=1. CMP R0,R0 gives Z=1, C=1, dst unchanged.
- MUL latency: R0=0xFF, R1=0xFF, MUL wb_en dst=3 → res_valid exactly 9 cycles after accept, res_data=0xFE01, C=1, R3=0x01. wr_en to R0 during EXEC does not change the result.
- Shifts and illegal: R0=0x81, R1=0x01 → SHL 0x02 C=1; SHR 0x40 C=1; ASR 0xC0 N=1. op_code=12 → err=1, res_data=0, no writeback.
- Backpressure and conflict: res_ready=0 for 5 cycles → outputs stable, op_ready=0, op_valid ignored. Same-edge wr_en and writeback to dst → writeback value stored.

Source files
------------

// File: rtl/alu_core_param_if.sv
// Operation / result handshake bundle for alu_core_param.
// Master drives requests and the write port, slave returns results.
interface alu_core_param_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
);
    localparam int AW = $clog2(NREGS);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [WIDTH-1:0]   wr_data;

    logic               op_valid;
    logic               op_ready;
    logic [3:0]         op_code;
    logic [AW-1:0]      src_a;
    logic [AW-1:0]      src_b;
    logic [AW-1:0]      dst;
    logic               wb_en;

    logic               res_valid;
    logic               res_ready;
    logic [2*WIDTH-1:0] res_data;
    logic               flag_z;
    logic               flag_c;
    logic               flag_v;
    logic               flag_n;
    logic               err;

    modport master (
        output wr_en, wr_addr, wr_data,
        output op_valid, op_code, src_a, src_b, dst, wb_en,
        output res_ready,
        input  op_ready, res_valid, res_data,
        input  flag_z, flag_c, flag_v, flag_n, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  op_valid, op_code, src_a, src_b, dst, wb_en,
        input  res_ready,
        output op_ready, res_valid, res_data,
        output flag_z, flag_c, flag_v, flag_n, err
    );
endinterface

// File: rtl/alu_core_param.sv
// Parametrised register-file ALU: single-cycle ops plus a shift-add
// multiplier, with valid/ready request and result handshakes.
module alu_core_param #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input logic             clk,
    input logic             rst,
    alu_core_param_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_ASR = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [NREGS];

    logic [W2-1:0]    res_q;
    logic             z_q, c_q, v_q, n_q, err_q;

    logic [W2-1:0]    acc;
    logic [W2-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [SW-1:0]    cnt;
    logic [AW-1:0]    dst_q;
    logic             wb_q;

    logic [WIDTH-1:0] a, b;
    logic [SW-1:0]    sh;
    logic [WIDTH:0]   sum_add, sum_sub;
    logic [W2-1:0]    shl_ext, shr_ext, asr_ext;
    logic [W2-1:0]    acc_nx;

    logic [WIDTH-1:0] r;
    logic             fc, fv, ill, wb_ok;

    assign a  = regs[bus.src_a];
    assign b  = regs[bus.src_b];
    assign sh = b[SW-1:0];

    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

    // Wide shifts leave the last bit shifted out next to the result half.
    assign shl_ext = {{WIDTH{1'b0}}, a} << sh;
    assign shr_ext = {a, {WIDTH{1'b0}}} >> sh;
    assign asr_ext = $signed({a, {WIDTH{1'b0}}}) >>> sh;

    assign acc_nx = mplier[0] ? acc + mcand : acc;

    always_comb begin
        r     = '0;
        fc    = 1'b0;
        fv    = 1'b0;
        ill   = 1'b0;
        wb_ok = 1'b1;
        unique case (1'b1)
            (bus.op_code == OP_ADD): begin
                r  = sum_add[WIDTH-1:0];
                fc = sum_add[WIDTH];
                fv = (a[WIDTH-1] == b[WIDTH-1]) &&
                     (r[WIDTH-1] != a[WIDTH-1]);
            end
            (bus.op_code == OP_SUB),
            (bus.op_code == OP_CMP): begin
                r     = sum_sub[WIDTH-1:0];
                fc    = sum_sub[WIDTH];
                fv    = (a[WIDTH-1] != b[WIDTH-1]) &&
                        (r[WIDTH-1] != a[WIDTH-1]);
                wb_ok = (bus.op_code == OP_SUB);
            end
            (bus.op_code == OP_AND): r = a & b;
            (bus.op_code == OP_OR):  r = a | b;
            (bus.op_code == OP_XOR): r = a ^ b;
            (bus.op_code == OP_SHL): begin
                r  = shl_ext[WIDTH-1:0];
                fc = shl_ext[WIDTH];
            end
            (bus.op_code == OP_SHR): begin
                r  = shr_ext[W2-1:WIDTH];
                fc = shr_ext[WIDTH-1];
            end
            (bus.op_code == OP_ASR): begin
                r  = asr_ext[W2-1:WIDTH];
                fc = asr_ext[WIDTH-1];
            end
            (bus.op_code == OP_MUL): wb_ok = 1'b0;
            default: begin
                ill   = 1'b1;
                wb_ok = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            res_q  <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            n_q    <= 1'b0;
            err_q  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            dst_q  <= '0;
            wb_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            // Writeback assignments below come later and win on a clash.
            if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
            unique case (state)
                IDLE: begin
                    if (bus.op_valid) begin
                        if (bus.op_code == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= '0;
                            dst_q  <= bus.dst;
                            wb_q   <= bus.wb_en;
                            state  <= EXEC;
                        end else begin
                            res_q <= {{WIDTH{1'b0}}, r};
                            z_q   <= !ill && (r == '0);
                            c_q   <= fc;
                            v_q   <= fv;
                            n_q   <= r[WIDTH-1];
                            err_q <= ill;
                            if (bus.wb_en && wb_ok) regs[bus.dst] <= r;
                            state <= DONE;
                        end
                    end
                end
                EXEC: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SW'(WIDTH-1)) begin
                        res_q <= acc_nx;
                        z_q   <= (acc_nx == '0);
                        c_q   <= |acc_nx[W2-1:WIDTH];
                        v_q   <= 1'b0;
                        n_q   <= acc_nx[W2-1];
                        err_q <= 1'b0;
                        if (wb_q) regs[dst_q] <= acc_nx[WIDTH-1:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.op_ready  = (state == IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.res_data  = res_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.flag_n    = n_q;
    assign bus.err       = err_q;
endmodule
